// File: rtl/rx_buffer_pkg.sv
// rtl/rx_buffer_pkg.sv - shared constants and FSM state type for the RX slot buffer writer
package rx_buffer_pkg;
    localparam int rx_buffer_els_gp = 2048;
    localparam int rx_size_width_gp = 16;

    typedef enum logic [1:0] {
        e_idle,
        e_recv,
        e_commit,
        e_drop
    } rx_writer_state_e;
endpackage

// File: rtl/rx_byte_packer.sv
// rtl/rx_byte_packer.sv - packs bytes into lanes of a word; reports when the word is complete
module rx_byte_packer #(
    parameter int data_width_p = 64,
    localparam int lanes_lp = data_width_p / 8,
    localparam int lane_width_lp = $clog2(lanes_lp)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     byte_v_i,
    input  logic [7:0]               byte_i,
    input  logic [lane_width_lp-1:0] lane_i,
    input  logic                     flush_i,
    input  logic                     clear_i,
    output logic [data_width_p-1:0]  word_o,
    output logic                     word_complete_o
);
    logic [data_width_p-1:0] pack_q, pack_d;
    logic [data_width_p-1:0] placed;

    always_comb begin
        placed          = data_width_p'(byte_i) << {lane_i, 3'b000};
        word_o          = pack_q | (byte_v_i ? placed : '0);
        word_complete_o = byte_v_i &
                          ((lane_i == lane_width_lp'(lanes_lp - 1)) | flush_i);
        // Clearing after every emitted word keeps unused lanes of a short final word at zero
        pack_d          = (clear_i | word_complete_o) ? '0 : word_o;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pack_q <= '0;
        end else begin
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/rx_buffer_writer.sv
// rtl/rx_buffer_writer.sv - packs the MAC RX byte stream into slot words, sizes and commits good frames
module rx_buffer_writer
    import rx_buffer_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int els_p        = rx_buffer_els_gp,
    parameter int cnt_width_p  = 16,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int bcnt_width_lp = $clog2(els_p) + 1,
    localparam int lanes_lp      = data_width_p / 8,
    localparam int lane_width_lp = $clog2(lanes_lp)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        rx_v_i,
    input  logic [7:0]                  rx_data_i,
    input  logic                        rx_last_i,
    input  logic                        rx_error_i,
    output logic                        buf_write_v_o,
    output logic [addr_width_lp-1:0]    buf_write_addr_o,
    output logic [data_width_p-1:0]     buf_write_data_o,
    output logic                        buf_write_size_v_o,
    output logic [rx_size_width_gp-1:0] buf_write_size_o,
    output logic                        buf_slot_v_o,
    input  logic                        buf_slot_ready_and_i,
    output logic [cnt_width_p-1:0]      frames_ok_o,
    output logic [cnt_width_p-1:0]      frames_drop_o
);
    rx_writer_state_e state_q, state_d;
    logic [bcnt_width_lp-1:0]    byte_cnt_q, byte_cnt_d;
    logic                        wr_v_q, wr_v_d;
    logic [addr_width_lp-1:0]    wr_addr_q, wr_addr_d;
    logic [data_width_p-1:0]     wr_data_q, wr_data_d;
    logic                        size_v_q, size_v_d;
    logic [rx_size_width_gp-1:0] size_q, size_d;
    logic                        slot_v_q, slot_v_d;
    logic [cnt_width_p-1:0]      ok_q, ok_d;
    logic [cnt_width_p-1:0]      drop_q, drop_d;

    logic                        pk_v, pk_flush, pk_clear, pk_complete;
    logic [data_width_p-1:0]     pk_word;

    rx_byte_packer #(.data_width_p(data_width_p)) u_packer (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .byte_v_i        (pk_v),
        .byte_i          (rx_data_i),
        .lane_i          (byte_cnt_q[lane_width_lp-1:0]),
        .flush_i         (pk_flush),
        .clear_i         (pk_clear),
        .word_o          (pk_word),
        .word_complete_o (pk_complete)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_v_d     = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        size_v_d   = 1'b0;
        size_d     = size_q;
        slot_v_d   = 1'b0;
        ok_d       = ok_q;
        drop_d     = drop_q;
        pk_v       = 1'b0;
        pk_flush   = 1'b0;
        pk_clear   = 1'b0;

        case (state_q)
            e_idle, e_recv: begin
                // byte_cnt_q is always 0 in idle, so a frame's first byte shares the receive path
                if (rx_v_i && (state_q == e_recv || buf_slot_ready_and_i)) begin
                    if (rx_error_i || byte_cnt_q == bcnt_width_lp'(els_p)) begin
                        pk_clear   = 1'b1;
                        byte_cnt_d = '0;
                        if (rx_last_i) begin
                            drop_d  = drop_q + 1'b1;
                            state_d = e_idle;
                        end else begin
                            state_d = e_drop;
                        end
                    end else begin
                        pk_v     = 1'b1;
                        pk_flush = rx_last_i;
                        if (pk_complete) begin
                            wr_v_d    = 1'b1;
                            wr_addr_d = byte_cnt_q[addr_width_lp-1:0] &
                                        ~addr_width_lp'(lanes_lp - 1);
                            wr_data_d = pk_word;
                        end
                        if (rx_last_i) begin
                            size_v_d   = 1'b1;
                            size_d     = rx_size_width_gp'(byte_cnt_q) + 1'b1;
                            byte_cnt_d = '0;
                            state_d    = e_commit;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = e_recv;
                        end
                    end
                end else if (rx_v_i) begin
                    if (rx_last_i) begin
                        drop_d = drop_q + 1'b1;
                    end else begin
                        state_d = e_drop;
                    end
                end
            end
            e_commit: begin
                slot_v_d = 1'b1;
                ok_d     = ok_q + 1'b1;
                state_d  = e_idle;
                // A byte here breaks the interframe gap; that frame is discarded
                if (rx_v_i) begin
                    if (rx_last_i) begin
                        drop_d = drop_q + 1'b1;
                    end else begin
                        state_d = e_drop;
                    end
                end
            end
            e_drop: begin
                if (rx_v_i && rx_last_i) begin
                    drop_d  = drop_q + 1'b1;
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            byte_cnt_q <= '0;
            wr_v_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            size_v_q   <= 1'b0;
            size_q     <= '0;
            slot_v_q   <= 1'b0;
            ok_q       <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wr_v_q     <= wr_v_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            size_v_q   <= size_v_d;
            size_q     <= size_d;
            slot_v_q   <= slot_v_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
        end
    end

    assign buf_write_v_o      = wr_v_q;
    assign buf_write_addr_o   = wr_addr_q;
    assign buf_write_data_o   = wr_data_q;
    assign buf_write_size_v_o = size_v_q;
    assign buf_write_size_o   = size_q;
    assign buf_slot_v_o       = slot_v_q;
    assign frames_ok_o        = ok_q;
    assign frames_drop_o      = drop_q;
endmodule

// File: tb/tb_rx_buffer_writer.sv
// tb/tb_rx_buffer_writer.sv - scoreboard bench for rx_buffer_writer with directed frames
module tb_rx_buffer_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_v = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        ready = 1'b1;
    logic        wr_v;
    logic [10:0] wr_addr;
    logic [63:0] wr_data;
    logic        size_v;
    logic [15:0] size;
    logic        slot_v;
    logic [15:0] ok_cnt;
    logic [15:0] drop_cnt;

    rx_buffer_writer dut (
        .clk_i                (clk),
        .reset_i              (rst),
        .rx_v_i               (rx_v),
        .rx_data_i            (rx_data),
        .rx_last_i            (rx_last),
        .rx_error_i           (rx_err),
        .buf_write_v_o        (wr_v),
        .buf_write_addr_o     (wr_addr),
        .buf_write_data_o     (wr_data),
        .buf_write_size_v_o   (size_v),
        .buf_write_size_o     (size),
        .buf_slot_v_o         (slot_v),
        .buf_slot_ready_and_i (ready),
        .frames_ok_o          (ok_cnt),
        .frames_drop_o        (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int size_cyc = -10;
    logic [10:0] last_addr = '0;
    logic [63:0] last_data = '0;

    logic [10:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    logic [15:0] exp_size_q[$];
    int          exp_slot_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_v) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", {53'd0, wr_addr}, 64'hFFFF_FFFF);
                end else begin
                    chk("write_addr", {53'd0, wr_addr}, {53'd0, exp_addr_q.pop_front()});
                    chk("write_data", wr_data, exp_data_q.pop_front());
                end
                last_addr = wr_addr;
                last_data = wr_data;
            end
            if (size_v) begin
                if (exp_size_q.size() == 0) chk("unexpected_size", {48'd0, size}, 64'hFFFF_FFFF);
                else chk("size", {48'd0, size}, {48'd0, exp_size_q.pop_front()});
                size_cyc = cyc;
            end
            if (slot_v) begin
                if (exp_slot_q.size() == 0) chk("unexpected_slot", 64'd1, 64'd0);
                else begin
                    void'(exp_slot_q.pop_front());
                    chk("commit_after_size", 64'(cyc - size_cyc), 64'd1);
                end
            end
        end
    end

    task automatic push_words(input int nbytes, input logic [7:0] start, input bit partial);
        logic [63:0] w;
        for (int a = 0; a < nbytes; a += 8) begin
            if (a + 8 > nbytes && !partial) break;
            w = '0;
            for (int k = 0; k < 8; k++)
                if (a + k < nbytes) w[8*k +: 8] = start + 8'(a + k);
            exp_addr_q.push_back(11'(a));
            exp_data_q.push_back(w);
        end
    endtask

    task automatic expect_good(input int len, input logic [7:0] start);
        push_words(len, start, 1'b1);
        exp_size_q.push_back(16'(len));
        exp_slot_q.push_back(1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
        rx_v = 1'b1; rx_data = d; rx_last = last; rx_err = err;
        @(posedge clk); #1;
        rx_v = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] start, input int err_idx, input int ready_idx);
        for (int i = 0; i < len; i++) begin
            if (i == ready_idx) ready = 1'b1;
            send_byte(start + 8'(i), i == len - 1, i == err_idx);
        end
    endtask

    task automatic drain(input string name, input int ok_e, input int drop_e);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_pending"}, 64'(exp_addr_q.size() + exp_size_q.size() + exp_slot_q.size()), 64'd0);
        chk({name, "_ok"}, {48'd0, ok_cnt}, 64'(ok_e));
        chk({name, "_drop"}, {48'd0, drop_cnt}, 64'(drop_e));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {58'd0, wr_v, size_v, slot_v, 3'd0}, 64'd0);
        chk("reset_counters", {32'd0, ok_cnt, drop_cnt}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        expect_good(64, 8'h00);
        send_frame(64, 8'h00, -1, -1);
        drain("t1", 1, 0);
        chk("t1_last_addr", {53'd0, last_addr}, 64'd56);

        expect_good(61, 8'h00);
        send_frame(61, 8'h00, -1, -1);
        drain("t2", 2, 0);
        chk("t2_last_data", last_data, 64'h0000_003C_3B3A_3938);

        push_words(20, 8'h00, 1'b0);
        send_frame(100, 8'h00, 20, -1);
        drain("t3_err", 2, 1);
        chk("t3_last_addr", {53'd0, last_addr}, 64'd8);
        expect_good(16, 8'h40);
        send_frame(16, 8'h40, -1, -1);
        drain("t3_next", 3, 1);

        ready = 1'b0;
        send_frame(60, 8'h10, -1, 30);
        drain("t4", 3, 2);

        push_words(2048, 8'h00, 1'b0);
        send_frame(2049, 8'h00, -1, -1);
        drain("t5_over", 3, 3);
        expect_good(2048, 8'h05);
        send_frame(2048, 8'h05, -1, -1);
        drain("t5_max", 4, 3);

        push_words(30, 8'h00, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(8'(i), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_reset_strobes", {61'd0, wr_v, size_v, slot_v}, 64'd0);
        chk("t6_reset_counters", {32'd0, ok_cnt, drop_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.push_back(11'd0);
        exp_data_q.push_back(64'h0000_0000_0000_00AB);
        exp_size_q.push_back(16'd1);
        exp_slot_q.push_back(1);
        send_byte(8'hAB, 1'b1, 1'b0);
        drain("t6", 1, 0);
        chk("t6_data", last_data, 64'hAB);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
